// File: rtl/conv_addr_gen.sv
// conv_addr_gen: loop-nest address generator for one convolution layer.
// Optional zero-padding border is built only when CONV_PAD_EN is defined.
module conv_addr_gen #(
    parameter int K         = 5,
    parameter int IN_SIZE   = 32,
    parameter int IN_CH     = 1,
    parameter int OUT_CH    = 6,
    parameter int LANES     = 4,
    parameter int STRIDE    = 1,
    parameter int PAD       = 0,
    parameter int OUT_DELAY = 9,
    parameter int ADDR_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              en,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              ifm_pad,
    output logic              acc_clear,
    output logic              out_wea,
    output logic [ADDR_W-1:0] out_addr
);

`ifdef CONV_PAD_EN
    localparam int PADE = PAD;
`else
    localparam int PADE = 0;
`endif

    localparam int NW       = (IN_CH + LANES - 1) / LANES;
    localparam int OUT_SIZE = (IN_SIZE + 2 * PADE - K) / STRIDE + 1;

    localparam int M1 = (K > NW) ? K : NW;
    localparam int M2 = (M1 > OUT_SIZE) ? M1 : OUT_SIZE;
    localparam int M3 = (M2 > OUT_CH) ? M2 : OUT_CH;
    localparam int M4 = (M3 > OUT_DELAY + 1) ? M3 : OUT_DELAY + 1;
    localparam int CW = $clog2(M4 + 1);

    localparam longint LIM     = (longint'(1) << ADDR_W) - 1;
    localparam longint IFM_MAX = longint'(NW) * IN_SIZE * IN_SIZE - 1;
    localparam longint WGT_MAX = longint'(OUT_CH) * NW * K * K - 1;
    localparam longint OUT_MAX = longint'(OUT_CH) * OUT_SIZE * OUT_SIZE - 1;

    if (IFM_MAX > LIM || WGT_MAX > LIM || OUT_MAX > LIM) begin : g_addr_overflow
        $error("conv_addr_gen: address range exceeds ADDR_W");
    end

    if (OUT_DELAY < 1 || PAD < 0 || STRIDE < 1 ||
        K > IN_SIZE + 2 * PADE) begin : g_bad_params
        $error("conv_addr_gen: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] j_q, j_d, i_q, i_d, n_q, n_d;
    logic [CW-1:0] c_q, c_d, r_q, r_d, m_q, m_d;
    logic [CW-1:0] dcnt_q, dcnt_d;

    logic busy_q, busy_d, done_q, done_d;
    logic addr_valid_q, addr_valid_d;
    logic acc_clear_q, acc_clear_d;
    logic ifm_pad_q, ifm_pad_d;
    logic tap_last_q, tap_last_d;
    logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d;
    logic [ADDR_W-1:0] weight_addr_q, weight_addr_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;

    logic              dly_wea_q  [OUT_DELAY];
    logic              dly_wea_d  [OUT_DELAY];
    logic [ADDR_W-1:0] dly_addr_q [OUT_DELAY];
    logic [ADDR_W-1:0] dly_addr_d [OUT_DELAY];

    logic issue;
    logic wrap_j, wrap_i, wrap_n, wrap_c, wrap_r, wrap_m;
    logic [ADDR_W-1:0] y_a, x_a, ifm_c, wgt_c, pix_c;
    logic pad_c;

    assign wrap_j = (j_q == CW'(K - 1));
    assign wrap_i = (i_q == CW'(K - 1));
    assign wrap_n = (n_q == CW'(NW - 1));
    assign wrap_c = (c_q == CW'(OUT_SIZE - 1));
    assign wrap_r = (r_q == CW'(OUT_SIZE - 1));
    assign wrap_m = (m_q == CW'(OUT_CH - 1));

    // FSM next state and loop-nest counter advance
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        i_d     = i_q;
        n_d     = n_q;
        c_d     = c_q;
        r_d     = r_q;
        m_d     = m_q;
        dcnt_d  = dcnt_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    j_d = '0;
                    i_d = '0;
                    n_d = '0;
                    c_d = '0;
                    r_d = '0;
                    m_d = '0;
                end
            end
            RUN: begin
                if (en) begin
                    issue = 1'b1;
                    j_d = wrap_j ? '0 : j_q + CW'(1);
                    if (wrap_j)
                        i_d = wrap_i ? '0 : i_q + CW'(1);
                    if (wrap_j && wrap_i)
                        n_d = wrap_n ? '0 : n_q + CW'(1);
                    if (wrap_j && wrap_i && wrap_n)
                        c_d = wrap_c ? '0 : c_q + CW'(1);
                    if (wrap_j && wrap_i && wrap_n && wrap_c)
                        r_d = wrap_r ? '0 : r_q + CW'(1);
                    if (wrap_j && wrap_i && wrap_n && wrap_c && wrap_r) begin
                        m_d = wrap_m ? '0 : m_q + CW'(1);
                        if (wrap_m) begin
                            state_d = DRAIN;
                            dcnt_d  = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (dcnt_q == CW'(OUT_DELAY))
                    state_d = DONE;
                else
                    dcnt_d = dcnt_q + CW'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef CONV_PAD_EN
    localparam int YW = $clog2(IN_SIZE + 2 * PADE + 1) + 1;
    logic [YW-1:0]        yu, xu;
    logic signed [YW-1:0] ys, xs;

    // Signed tap coordinates and border detection
    always_comb begin
        yu = YW'(r_q) * YW'(STRIDE) + YW'(i_q);
        xu = YW'(c_q) * YW'(STRIDE) + YW'(j_q);
        ys = $signed(yu - YW'(PADE));
        xs = $signed(xu - YW'(PADE));
        pad_c = (ys < 0) || (ys > $signed(YW'(IN_SIZE - 1))) ||
                (xs < 0) || (xs > $signed(YW'(IN_SIZE - 1)));
        y_a = ADDR_W'(yu - YW'(PADE));
        x_a = ADDR_W'(xu - YW'(PADE));
    end
`else
    // Tap coordinates without a padding border
    always_comb begin
        pad_c = 1'b0;
        y_a = ADDR_W'(r_q) * ADDR_W'(STRIDE) + ADDR_W'(i_q);
        x_a = ADDR_W'(c_q) * ADDR_W'(STRIDE) + ADDR_W'(j_q);
    end
`endif

    // Address arithmetic and registered-output next values
    always_comb begin
        ifm_c = ADDR_W'(n_q) * ADDR_W'(IN_SIZE * IN_SIZE)
              + y_a * ADDR_W'(IN_SIZE) + x_a;
        if (pad_c)
            ifm_c = '0;
        wgt_c = ADDR_W'(m_q) * ADDR_W'(NW * K * K)
              + ADDR_W'(n_q) * ADDR_W'(K * K)
              + ADDR_W'(i_q) * ADDR_W'(K) + ADDR_W'(j_q);
        pix_c = ADDR_W'(m_q) * ADDR_W'(OUT_SIZE * OUT_SIZE)
              + ADDR_W'(r_q) * ADDR_W'(OUT_SIZE) + ADDR_W'(c_q);
        addr_valid_d  = issue;
        acc_clear_d   = issue && (n_q == '0) && (i_q == '0) && (j_q == '0);
        ifm_pad_d     = issue && pad_c;
        tap_last_d    = issue && wrap_n && wrap_i && wrap_j;
        ifm_addr_d    = issue ? ifm_c : ifm_addr_q;
        weight_addr_d = issue ? wgt_c : weight_addr_q;
        pix_addr_d    = issue ? pix_c : pix_addr_q;
        busy_d        = (state_d == RUN) || (state_d == DRAIN);
        done_d        = (state_d == DONE);
    end

    // Output-write delay line shifts every cycle to track the MAC pipeline
    always_comb begin
        dly_wea_d[0]  = tap_last_q;
        dly_addr_d[0] = pix_addr_q;
        for (int k = 1; k < OUT_DELAY; k++) begin
            dly_wea_d[k]  = dly_wea_q[k-1];
            dly_addr_d[k] = dly_addr_q[k-1];
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            j_q           <= '0;
            i_q           <= '0;
            n_q           <= '0;
            c_q           <= '0;
            r_q           <= '0;
            m_q           <= '0;
            dcnt_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            addr_valid_q  <= 1'b0;
            acc_clear_q   <= 1'b0;
            ifm_pad_q     <= 1'b0;
            tap_last_q    <= 1'b0;
            ifm_addr_q    <= '0;
            weight_addr_q <= '0;
            pix_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            j_q           <= j_d;
            i_q           <= i_d;
            n_q           <= n_d;
            c_q           <= c_d;
            r_q           <= r_d;
            m_q           <= m_d;
            dcnt_q        <= dcnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            addr_valid_q  <= addr_valid_d;
            acc_clear_q   <= acc_clear_d;
            ifm_pad_q     <= ifm_pad_d;
            tap_last_q    <= tap_last_d;
            ifm_addr_q    <= ifm_addr_d;
            weight_addr_q <= weight_addr_d;
            pix_addr_q    <= pix_addr_d;
        end
    end

    // Delay-line registers; reset drops any pending write
    always_ff @(posedge clock) begin
        for (int k = 0; k < OUT_DELAY; k++) begin
            if (reset) begin
                dly_wea_q[k]  <= 1'b0;
                dly_addr_q[k] <= '0;
            end else begin
                dly_wea_q[k]  <= dly_wea_d[k];
                dly_addr_q[k] <= dly_addr_d[k];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign addr_valid  = addr_valid_q;
    assign ifm_addr    = ifm_addr_q;
    assign weight_addr = weight_addr_q;
    assign ifm_pad     = ifm_pad_q;
    assign acc_clear   = acc_clear_q;
    assign out_wea     = dly_wea_q[OUT_DELAY-1];
    assign out_addr    = dly_addr_q[OUT_DELAY-1];

endmodule
